// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
// Used by load_store_unit and lsu_lane_align.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } lsu_state_t;

    // Reserved size counts as misaligned so that one check covers every trap case.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
// Purely combinational; size must already be one of byte/half/word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] new_data,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr_lo)
            2'd0:    lane_b = rd_word[7:0];
            2'd1:    lane_b = rd_word[15:8];
            2'd2:    lane_b = rd_word[23:16];
            default: lane_b = rd_word[31:24];
        endcase
        lane_h = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    end

    always_comb begin
        load_data = rd_word;
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & lane_b[7]}}, lane_b};
            SZ_HALF: load_data = {{16{sign_ext & lane_h[15]}}, lane_h};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        merge_data = rd_word;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'd0:    merge_data[7:0]   = new_data[7:0];
                    2'd1:    merge_data[15:8]  = new_data[7:0];
                    2'd2:    merge_data[23:16] = new_data[7:0];
                    default: merge_data[31:24] = new_data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1])
                    merge_data[31:16] = new_data[15:0];
                else
                    merge_data[15:0] = new_data[15:0];
            end
            default: merge_data = new_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-wide data memory (RMW for sub-word stores).
// LSU_MISALIGN_TRAP_EN: trap misaligned/reserved-size requests instead of force-aligning them.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a request; latch it on req_valid
// ST_LOAD  | memory read in flight; extended lane registered into resp_rdata
// ST_MERGE | old word read; new lane(s) merged into write buffer
// ST_WRITE | single-cycle memory write of the write buffer
// ST_RESP  | resp_valid pulse, then back to idle
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    lsu_state_t        state, state_nxt;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [1:0]        r_lo;
    logic [31:0]       r_wdata;
    logic [31:0]       wbuf;
    logic [ADDR_W-1:0] a_q;

    logic              req_err;
    logic [1:0]        eff_size;
    logic [ADDR_W+1:0] eff_addr;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        req_err  = is_misaligned(req_size, req_addr[1:0]);
        eff_size = req_size;
        eff_addr = req_addr;
    end
`else
    // Without trapping, misaligned requests are silently aligned down.
    always_comb begin
        req_err  = 1'b0;
        eff_size = (req_size == SZ_RSVD) ? SZ_WORD : req_size;
        eff_addr = req_addr;
        if (eff_size == SZ_HALF)
            eff_addr[0] = 1'b0;
        else if (eff_size == SZ_WORD)
            eff_addr[1:0] = 2'b00;
    end
`endif

    lsu_lane_align u_align (
        .rd_word    (mem_rd),
        .addr_lo    (r_lo),
        .size       (r_size),
        .sign_ext   (r_signed),
        .new_data   (r_wdata),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_nxt = ST_RESP;
                    else if (!req_write)
                        state_nxt = ST_LOAD;
                    else if (eff_size == SZ_WORD)
                        state_nxt = ST_WRITE;
                    else
                        state_nxt = ST_MERGE;
                end
            end
            ST_LOAD:  state_nxt = ST_RESP;
            ST_MERGE: state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_size     <= SZ_BYTE;
            r_signed   <= 1'b0;
            r_lo       <= 2'b00;
            r_wdata    <= '0;
            wbuf       <= '0;
            a_q        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_size   <= eff_size;
                        r_signed <= req_signed;
                        r_lo     <= eff_addr[1:0];
                        r_wdata  <= req_wdata;
                        if (req_err) begin
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                        end else begin
                            a_q <= eff_addr[ADDR_W+1:2];
                            if (req_write && eff_size == SZ_WORD)
                                wbuf <= req_wdata;
                        end
                    end
                end
                ST_LOAD: begin
                    resp_rdata <= load_data;
                    resp_err   <= 1'b0;
                end
                ST_MERGE: wbuf <= merge_data;
                ST_WRITE: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign mem_we     = (state == ST_WRITE);
    assign mem_a      = a_q;
    assign mem_wd     = wbuf;

endmodule
